// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and sizing helpers for the streaming CNN layers.
package cnn_pkg;
  typedef enum logic {ACT_RELU, ACT_NONE} act_e;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} conv_state_e;
  function automatic int acc_width(input int dw, input int kw, input int k);
    return dw + kw + $clog2(k * k) + 1;
  endfunction
  function automatic int out_dim(input int img, input int k, input int stride);
    return (img - k) / stride + 1;
  endfunction
endpackage

// File: rtl/conv_line_buffer.sv
// conv_line_buffer: K-1 row memories plus a KxK sliding window fed in raster order.
module conv_line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int K = 5,
  parameter int IMGCOL = 28,
  localparam int CW = $clog2(IMGCOL)
) (
  input  logic clk,
  input  logic shift,
  input  logic [CW-1:0] col,
  input  logic [DATA_WIDTH-1:0] pix,
  output logic [K-1:0][K-1:0][DATA_WIDTH-1:0] window
);
  logic [DATA_WIDTH-1:0] mem [K-1][IMGCOL];
  logic [K-1:0][DATA_WIDTH-1:0] column;
  always_comb begin
    for (int i = 0; i < K - 1; i++) column[i] = mem[i][col];
    column[K-1] = pix;
  end
  // each column rotates up one row so mem[0] always holds the oldest buffered row
  always_ff @(posedge clk)
    if (shift) begin
      for (int i = 0; i < K - 1; i++) mem[i][col] <= column[i+1];
      for (int i = 0; i < K; i++) window[i] <= {column[i], window[i][K-1:1]};
    end
endmodule

// File: rtl/conv_stream_layer.sv
// conv_stream_layer: raster-stream KxK convolution over NUM_OCH channels with stride, shift and activation.
// Define CONV_BIAS_EN to add a per-channel signed bias port, latched at start.
module conv_stream_layer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int KDATA_WIDTH = 8,
  parameter int KERNEL_SIZE = 5,
  parameter int IMGROW = 28,
  parameter int IMGCOL = 28,
  parameter int NUM_OCH = 4,
  parameter int STRIDE = 1,
  parameter int OUT_SHIFT = 0,
  parameter ACTIVATION = "RELU",
  localparam int OUT_ROWS = out_dim(IMGROW, KERNEL_SIZE, STRIDE),
  localparam int OUT_COLS = out_dim(IMGCOL, KERNEL_SIZE, STRIDE),
  localparam int ORW = OUT_ROWS > 1 ? $clog2(OUT_ROWS) : 1,
  localparam int OCW = OUT_COLS > 1 ? $clog2(OUT_COLS) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic [NUM_OCH-1:0][KERNEL_SIZE-1:0][KERNEL_SIZE-1:0][KDATA_WIDTH-1:0] kernel,
`ifdef CONV_BIAS_EN
  input  logic [NUM_OCH-1:0][KDATA_WIDTH-1:0] bias,
`endif
  input  logic pix_valid,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic pix_ready,
  output logic out_valid,
  input  logic out_ready,
  output logic [NUM_OCH-1:0][DATA_WIDTH-1:0] out_data,
  output logic [ORW-1:0] out_row,
  output logic [OCW-1:0] out_col,
  output logic layer_done
);
  localparam int K = KERNEL_SIZE;
  localparam int DW = DATA_WIDTH;
  localparam int KW = KDATA_WIDTH;
  localparam int ACC_W = acc_width(DW, KW, K);
  localparam int PW = DW + KW + 1;
  localparam int RW = $clog2(IMGROW);
  localparam int CW = $clog2(IMGCOL);
  localparam act_e ACT = ACTIVATION == "NONE" ? ACT_NONE : ACT_RELU;
  localparam logic signed [ACC_W-1:0] UMAX = ACC_W'((1 << DW) - 1);
  localparam logic signed [ACC_W-1:0] SMAX = ACC_W'((1 << (DW - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SMIN = ACC_W'(-(1 << (DW - 1)));
  conv_state_e state, state_n;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [ORW-1:0] orow, wrow, r1;
  logic [OCW-1:0] ocol, wcol, c1;
  logic load, en, accept, emit, last_col, wv, v1;
  logic [NUM_OCH-1:0][K-1:0][K-1:0][KW-1:0] kreg;
  logic [K-1:0][K-1:0][DW-1:0] win;
  logic signed [PW-1:0] prod [NUM_OCH][K][K];
  logic signed [ACC_W-1:0] acc [NUM_OCH];
  logic signed [ACC_W-1:0] v [NUM_OCH];
  logic [NUM_OCH-1:0][DW-1:0] act;
`ifdef CONV_BIAS_EN
  logic [NUM_OCH-1:0][KW-1:0] breg;
  always_ff @(posedge clk) if (load) breg <= bias;
`endif
  assign load = start && (state == IDLE || state == DONE);
  assign en = !(out_valid && !out_ready);
  assign pix_ready = state == RUN && en;
  assign accept = pix_valid && pix_ready;
  assign last_col = col == CW'(IMGCOL - 1);
  assign emit = int'(row) >= K - 1 && int'(col) >= K - 1
             && (int'(row) - K + 1) % STRIDE == 0 && (int'(col) - K + 1) % STRIDE == 0;
  assign layer_done = state == DONE;
  always_comb
    state_n = load ? RUN
            : state == RUN && accept && last_col && row == RW'(IMGROW - 1) ? DRAIN
            : state == DRAIN && !wv && !v1 && !out_valid ? DONE : state;
  conv_line_buffer #(.DATA_WIDTH(DW), .K(K), .IMGCOL(IMGCOL)) u_lb (
    .clk(clk), .shift(accept), .col(col), .pix(pix_data), .window(win)
  );
  // wv marks a complete window in the window register; the whole chain freezes on stall
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      row <= '0;
      col <= '0;
      orow <= '0;
      ocol <= '0;
      wrow <= '0;
      wcol <= '0;
      r1 <= '0;
      c1 <= '0;
      wv <= 1'b0;
      v1 <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_row <= '0;
      out_col <= '0;
    end else begin
      state <= state_n;
      if (load) begin
        row <= '0;
        col <= '0;
        orow <= '0;
        ocol <= '0;
      end else if (accept) begin
        col <= last_col ? '0 : col + 1'b1;
        row <= last_col ? row + 1'b1 : row;
        if (emit) begin
          ocol <= ocol == OCW'(OUT_COLS - 1) ? '0 : ocol + 1'b1;
          orow <= ocol == OCW'(OUT_COLS - 1) ? orow + 1'b1 : orow;
          wrow <= orow;
          wcol <= ocol;
        end
      end
      if (en) begin
        wv <= accept && emit;
        v1 <= wv;
        r1 <= wrow;
        c1 <= wcol;
        out_valid <= v1;
        out_row <= r1;
        out_col <= c1;
        out_data <= act;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (load) kreg <= kernel;
    if (en)
      for (int o = 0; o < NUM_OCH; o++)
        for (int i = 0; i < K; i++)
          for (int j = 0; j < K; j++)
            prod[o][i][j] <= PW'($signed({1'b0, win[i][j]})) * PW'($signed(kreg[o][i][j]));
  end
  always_comb
    for (int o = 0; o < NUM_OCH; o++) begin
`ifdef CONV_BIAS_EN
      acc[o] = ACC_W'($signed(breg[o]));
`else
      acc[o] = '0;
`endif
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          acc[o] = acc[o] + ACC_W'(prod[o][i][j]);
      v[o] = acc[o] >>> OUT_SHIFT;
      act[o] = ACT == ACT_RELU ? (v[o] < 0 ? '0 : v[o] > UMAX ? '1 : v[o][DW-1:0])
                               : (v[o] > SMAX ? SMAX[DW-1:0] : v[o] < SMIN ? SMIN[DW-1:0] : v[o][DW-1:0]);
    end
endmodule
